// File: rtl/cdb_arbiter_if.sv
// Result handoff from the functional units and the registered Common Data Bus broadcast.
// The functional-unit side drives through master; the arbiter receives through slave.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 3,
    parameter int IDX_W   = 3
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(NUM_REQ + 1);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*IDX_W-1:0]  req_idx;
    logic [NUM_REQ*DATA_W-1:0] req_data;

    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [IDX_W-1:0]          cdb_idx;
    logic [DATA_W-1:0]         cdb_data;
    logic [SRC_W-1:0]          cdb_src;
    logic [CNT_W-1:0]          pending;

    modport master (
        output req_valid, req_tag, req_idx, req_data,
        input  req_ready, cdb_valid, cdb_tag, cdb_idx, cdb_data, cdb_src, pending
    );

    modport slave (
        input  req_valid, req_tag, req_idx, req_data,
        output req_ready, cdb_valid, cdb_tag, cdb_idx, cdb_data, cdb_src, pending
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the Common Data Bus: one holding slot per functional unit,
// at most one slot granted per cycle onto a registered broadcast.
module cdb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 3,
    parameter int IDX_W   = 3
) (
    input logic          clock,
    input logic          reset,
    cdb_arbiter_if.slave bus
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(NUM_REQ + 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;

    slot_state_e       state_q [NUM_REQ];
    slot_state_e       state_d [NUM_REQ];
    logic [TAG_W-1:0]  tag_q   [NUM_REQ];
    logic [TAG_W-1:0]  tag_d   [NUM_REQ];
    logic [IDX_W-1:0]  idx_q   [NUM_REQ];
    logic [IDX_W-1:0]  idx_d   [NUM_REQ];
    logic [DATA_W-1:0] data_q  [NUM_REQ];
    logic [DATA_W-1:0] data_d  [NUM_REQ];

    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [IDX_W-1:0]  cdb_idx_q, cdb_idx_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;
    logic [CNT_W-1:0]  pending_q, pending_d;

    logic              grant_vld;
    logic [SRC_W-1:0]  grant_idx;

    // NOTE: the slot payload registers are reset too, so no X can ever reach the bus outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                state_q[i] <= EMPTY;
                tag_q[i]   <= '0;
                idx_q[i]   <= '0;
                data_q[i]  <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_idx_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
            pending_q   <= '0;
        end else begin
            // NOTE: non-blocking here so every flop samples pre-edge values regardless of order.
            state_q     <= state_d;
            tag_q       <= tag_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_idx_q   <= cdb_idx_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
            pending_q   <= pending_d;
        end
    end

    // First FULL slot at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int cand;
        // NOTE: every comb output gets a default first so no path can infer a latch.
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!grant_vld && state_q[SRC_W'(cand)] == FULL) begin
                grant_vld = 1'b1;
                grant_idx = SRC_W'(cand);
            end
        end
    end

    always_comb begin
        pending_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            state_d[i] = state_q[i];
            tag_d[i]   = tag_q[i];
            idx_d[i]   = idx_q[i];
            data_d[i]  = data_q[i];
            // A granted slot is FULL, so it cannot also accept on the same edge.
            if (state_q[i] == EMPTY && bus.req_valid[i]) begin
                state_d[i] = FULL;
                tag_d[i]   = bus.req_tag[i*TAG_W +: TAG_W];
                idx_d[i]   = bus.req_idx[i*IDX_W +: IDX_W];
                data_d[i]  = bus.req_data[i*DATA_W +: DATA_W];
            end else if (grant_vld && grant_idx == SRC_W'(i)) begin
                state_d[i] = EMPTY;
            end
            if (state_d[i] == FULL) pending_d = pending_d + CNT_W'(1);
        end

        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = grant_vld;
        cdb_tag_d   = cdb_tag_q;
        cdb_idx_d   = cdb_idx_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        if (grant_vld) begin
            rr_ptr_d   = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            cdb_tag_d  = tag_q[grant_idx];
            cdb_idx_d  = idx_q[grant_idx];
            cdb_data_d = data_q[grant_idx];
            cdb_src_d  = grant_idx;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = (state_q[i] == EMPTY);
        end
        bus.cdb_valid = cdb_valid_q;
        bus.cdb_tag   = cdb_tag_q;
        bus.cdb_idx   = cdb_idx_q;
        bus.cdb_data  = cdb_data_q;
        bus.cdb_src   = cdb_src_q;
        bus.pending   = pending_q;
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a slot/queue model checked on every falling edge,
// plus directed scenarios with hand-computed expectations.
module tb_cdb_arbiter;
    localparam int N  = 3;
    localparam int DW = 16;
    localparam int TW = 3;
    localparam int IW = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    cdb_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .TAG_W(TW), .IDX_W(IW)) bus ();

    cdb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TAG_W(TW), .IDX_W(IW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: each unit owns one mailbox; the bus takes the next
    // occupied mailbox in circular order starting after the last winner.
    typedef struct {
        bit            full;
        logic [TW-1:0] tag;
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } slot_t;

    slot_t         m_slot [N];
    int            m_rr    = 0;
    bit            m_valid = 1'b0;
    logic [TW-1:0] m_tag   = '0;
    logic [IW-1:0] m_idx   = '0;
    logic [DW-1:0] m_data  = '0;
    int            m_src   = 0;

    always @(posedge clock or posedge reset) begin : model
        int g;
        if (reset) begin
            for (int i = 0; i < N; i++) m_slot[i] = '{1'b0, '0, '0, '0};
            m_rr = 0; m_valid = 1'b0; m_tag = '0; m_idx = '0; m_data = '0; m_src = 0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && m_slot[(m_rr + k) % N].full) g = (m_rr + k) % N;
            for (int i = 0; i < N; i++) begin
                if (!m_slot[i].full && bus.req_valid[i]) begin
                    m_slot[i].full = 1'b1;
                    m_slot[i].tag  = bus.req_tag[i*TW +: TW];
                    m_slot[i].idx  = bus.req_idx[i*IW +: IW];
                    m_slot[i].data = bus.req_data[i*DW +: DW];
                end
            end
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_tag  = m_slot[g].tag;
                m_idx  = m_slot[g].idx;
                m_data = m_slot[g].data;
                m_src  = g;
                m_slot[g].full = 1'b0;
                m_rr = (g + 1) % N;
            end
        end
    end

    always @(negedge clock) begin : compare
        int pend;
        logic [N-1:0] rdy;
        pend = 0;
        for (int i = 0; i < N; i++) begin
            rdy[i] = !m_slot[i].full;
            if (m_slot[i].full) pend++;
        end
        check("req_ready", 32'(bus.req_ready), 32'(rdy));
        check("pending",   32'(bus.pending),   32'(pend));
        check("cdb_valid", 32'(bus.cdb_valid), 32'(m_valid));
        check("cdb_tag",   32'(bus.cdb_tag),   32'(m_tag));
        check("cdb_idx",   32'(bus.cdb_idx),   32'(m_idx));
        check("cdb_data",  32'(bus.cdb_data),  32'(m_data));
        check("cdb_src",   32'(bus.cdb_src),   32'(m_src));
    end

    task automatic present(input int u, input int t, input int x, input int d);
        bus.req_valid[u]           = 1'b1;
        bus.req_tag[u*TW +: TW]    = TW'(t);
        bus.req_idx[u*IW +: IW]    = IW'(x);
        bus.req_data[u*DW +: DW]   = DW'(d);
    endtask

    task automatic present_random(input int u);
        present(u, int'($urandom), int'($urandom), int'($urandom));
    endtask

    // Called just after a rising edge; the pulse sits wholly between edges.
    task automatic pulse_reset();
        #1 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    task automatic post_edge();
        @(posedge clock);
        #1;
    endtask

    int grants [N];

    initial begin
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_idx   = '0;
        bus.req_data  = '0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;

        // Idle after reset.
        repeat (5) post_edge();
        check("idle_ready",     32'(bus.req_ready), 32'h7);
        check("idle_cdb_valid", 32'(bus.cdb_valid), 32'h0);
        check("idle_pending",   32'(bus.pending),   32'h0);
        check("idle_cdb_tag",   32'(bus.cdb_tag),   32'h0);
        check("idle_cdb_idx",   32'(bus.cdb_idx),   32'h0);
        check("idle_cdb_data",  32'(bus.cdb_data),  32'h0);
        check("idle_cdb_src",   32'(bus.cdb_src),   32'h0);

        // Single result from unit 1: accepted at edge N, broadcast after N+1.
        present(1, 2, 5, 16'hBEEF);
        post_edge();
        bus.req_valid = '0;
        check("single_pending_n",  32'(bus.pending),   32'h1);
        check("single_ready_n",    32'(bus.req_ready), 32'h5);
        check("single_valid_n",    32'(bus.cdb_valid), 32'h0);
        post_edge();
        check("single_valid_n1",   32'(bus.cdb_valid), 32'h1);
        check("single_tag",        32'(bus.cdb_tag),   32'h2);
        check("single_idx",        32'(bus.cdb_idx),   32'h5);
        check("single_data",       32'(bus.cdb_data),  32'hBEEF);
        check("single_src",        32'(bus.cdb_src),   32'h1);
        check("single_ready_n1",   32'(bus.req_ready), 32'h7);
        post_edge();
        check("single_valid_n2",   32'(bus.cdb_valid), 32'h0);

        // Three simultaneous results drain in order 0, 1, 2.
        pulse_reset();
        present(0, 1, 1, 16'h0011);
        present(1, 3, 2, 16'h0022);
        present(2, 0, 0, 16'h0033);
        post_edge();
        bus.req_valid = '0;
        check("burst_pending", 32'(bus.pending),   32'h3);
        check("burst_ready",   32'(bus.req_ready), 32'h0);
        for (int s = 0; s < 3; s++) begin
            post_edge();
            check("burst_valid",   32'(bus.cdb_valid), 32'h1);
            check("burst_src",     32'(bus.cdb_src),   32'(s));
            check("burst_data",    32'(bus.cdb_data),  32'((s + 1) * 16'h0011));
            check("burst_pending", 32'(bus.pending),   32'(2 - s));
            check("burst_ready",   32'(bus.req_ready), 32'((1 << (s + 1)) - 1));
        end
        post_edge();
        check("burst_done_valid", 32'(bus.cdb_valid), 32'h0);

        // All units continuously valid: back-to-back broadcasts, strict rotation.
        pulse_reset();
        for (int u = 0; u < N; u++) present_random(u);
        for (int u = 0; u < N; u++) grants[u] = 0;
        post_edge();
        for (int k = 0; k < 30; k++) begin
            post_edge();
            check("stream_valid", 32'(bus.cdb_valid), 32'h1);
            check("stream_src",   32'(bus.cdb_src),   32'(k % N));
            if (int'(bus.cdb_src) < N) grants[bus.cdb_src]++;
            for (int u = 0; u < N; u++) present_random(u);
        end
        bus.req_valid = '0;
        for (int u = 0; u < N; u++)
            check("stream_fair", 32'(grants[u] >= 9 && grants[u] <= 11), 32'h1);
        repeat (4) post_edge();

        // rr_ptr = 1 with units 0 and 2 valid: unit 2 wins first, then alternation.
        pulse_reset();
        present_random(0);
        post_edge();
        present_random(2);
        post_edge();
        check("rr_first_src",   32'(bus.cdb_src),   32'h0);
        check("rr_first_valid", 32'(bus.cdb_valid), 32'h1);
        for (int k = 0; k < 8; k++) begin
            post_edge();
            check("rr_alt_valid", 32'(bus.cdb_valid), 32'h1);
            check("rr_alt_src",   32'(bus.cdb_src),   (k % 2 == 0) ? 32'h2 : 32'h0);
            present_random(0);
            present_random(2);
        end
        bus.req_valid = '0;
        repeat (4) post_edge();

        // Asynchronous reset with two slots full and a broadcast in flight.
        pulse_reset();
        for (int u = 0; u < N; u++) present_random(u);
        post_edge();
        bus.req_valid = '0;
        post_edge();
        check("async_pre_valid",   32'(bus.cdb_valid), 32'h1);
        check("async_pre_pending", 32'(bus.pending),   32'h2);
        reset = 1'b1;
        #1;
        check("async_valid",   32'(bus.cdb_valid), 32'h0);
        check("async_pending", 32'(bus.pending),   32'h0);
        check("async_ready",   32'(bus.req_ready), 32'h7);
        check("async_data",    32'(bus.cdb_data),  32'h0);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            post_edge();
            check("async_after_valid", 32'(bus.cdb_valid), 32'h0);
            check("async_after_ready", 32'(bus.req_ready), 32'h7);
        end

        // Randomized traffic, checked by the model on every cycle.
        for (int k = 0; k < 400; k++) begin
            post_edge();
            if ($urandom_range(0, 63) == 0) pulse_reset();
            bus.req_valid = N'($urandom_range(0, (1 << N) - 1));
            bus.req_tag   = (N*TW)'($urandom);
            bus.req_idx   = (N*IW)'($urandom);
            bus.req_data  = (N*DW)'({$urandom, $urandom});
        end
        bus.req_valid = '0;
        repeat (6) post_edge();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
